// File: rtl/processor_pkg.sv
// Shared definitions for the pipeline: fetch FSM states, datapath widths,
// two-word instruction class and the boot-vector locations in instruction memory.
package processor_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;

  localparam logic [2:0]      IMM_CLASS         = 3'b110;
  localparam logic [PC_W-1:0] RESET_VEC_HI_ADDR = 32'd0;
  localparam logic [PC_W-1:0] RESET_VEC_LO_ADDR = 32'd1;

  typedef enum logic [1:0] {
    BOOT_HI,
    BOOT_LO,
    RUN,
    IMM
  } fetch_state_t;

  function automatic logic is_two_word(input logic [INSTR_W-1:0] word,
                                       input logic [2:0] imm_class);
    return word[INSTR_W-1:INSTR_W-3] == imm_class;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter storage: loads load_val when load is high, clears on reset.
module pc_register
  import processor_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= '0;
    end else if (load) begin
      pc_reg <= load_val;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: boots the PC from memory words 0/1, then streams one- and
// two-word instructions into the fetch/decode register with stall and redirect.
module fetch_stage #(
  parameter int         ADDR_W    = 21,
  parameter logic [2:0] IMM_CLASS = processor_pkg::IMM_CLASS
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic [ADDR_W-1:0]                  imem_addr,
  input  logic [processor_pkg::INSTR_W-1:0]  imem_data,
  input  logic                               stall,
  input  logic                               redirect,
  input  logic [processor_pkg::PC_W-1:0]     redirect_pc,
  output logic [processor_pkg::INSTR_W-1:0]  fd_instr,
  output logic [processor_pkg::INSTR_W-1:0]  fd_imm,
  output logic [processor_pkg::PC_W-1:0]     fd_pc,
  output logic                               fd_valid,
  output logic                               booting
);

  import processor_pkg::*;

  fetch_state_t       state_reg, state_next;
  logic [INSTR_W-1:0] held_instr_reg, held_instr_next;
  logic [INSTR_W-1:0] fd_instr_reg, fd_instr_next;
  logic [INSTR_W-1:0] fd_imm_reg, fd_imm_next;
  logic [PC_W-1:0]    fd_pc_reg, fd_pc_next;
  logic               fd_valid_reg, fd_valid_next;

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            pc_load;

  pc_register u_pc_register (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_next),
    .pc       (pc)
  );

  always_comb begin
    state_next      = state_reg;
    held_instr_next = held_instr_reg;
    fd_instr_next   = fd_instr_reg;
    fd_imm_next     = fd_imm_reg;
    fd_pc_next      = fd_pc_reg;
    fd_valid_next   = fd_valid_reg;
    pc_load         = 1'b0;
    pc_next         = pc;
    imem_addr       = pc[ADDR_W-1:0];

    case (state_reg)
      BOOT_HI: begin
        imem_addr  = ADDR_W'(RESET_VEC_HI_ADDR);
        pc_load    = 1'b1;
        pc_next    = {imem_data, pc[15:0]};
        state_next = BOOT_LO;
      end
      BOOT_LO: begin
        imem_addr  = ADDR_W'(RESET_VEC_LO_ADDR);
        pc_load    = 1'b1;
        pc_next    = {pc[31:16], imem_data};
        state_next = RUN;
      end
      RUN, IMM: begin
        // A redirect wins over a stall raised in the same cycle.
        if (redirect) begin
          pc_load         = 1'b1;
          pc_next         = redirect_pc;
          state_next      = RUN;
          fd_valid_next   = 1'b0;
          held_instr_next = '0;
        end else if (!stall) begin
          pc_load = 1'b1;
          pc_next = pc + 32'd1;
          if (state_reg == RUN) begin
            if (is_two_word(imem_data, IMM_CLASS)) begin
              held_instr_next = imem_data;
              fd_valid_next   = 1'b0;
              state_next      = IMM;
            end else begin
              fd_instr_next = imem_data;
              fd_imm_next   = '0;
              fd_pc_next    = pc;
              fd_valid_next = 1'b1;
            end
          end else begin
            // PC already points past the opcode word, so the instruction starts at PC-1.
            fd_instr_next = held_instr_reg;
            fd_imm_next   = imem_data;
            fd_pc_next    = pc - 32'd1;
            fd_valid_next = 1'b1;
            state_next    = RUN;
          end
        end
      end
      default: state_next = BOOT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= BOOT_HI;
      held_instr_reg <= '0;
      fd_instr_reg   <= '0;
      fd_imm_reg     <= '0;
      fd_pc_reg      <= '0;
      fd_valid_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      held_instr_reg <= held_instr_next;
      fd_instr_reg   <= fd_instr_next;
      fd_imm_reg     <= fd_imm_next;
      fd_pc_reg      <= fd_pc_next;
      fd_valid_reg   <= fd_valid_next;
    end
  end

  assign fd_instr = fd_instr_reg;
  assign fd_imm   = fd_imm_reg;
  assign fd_pc    = fd_pc_reg;
  assign fd_valid = fd_valid_reg;
  assign booting  = (state_reg == BOOT_HI) || (state_reg == BOOT_LO);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a program-level model walks memory to
// predict the instruction stream; a monitor pops and compares each new output.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [20:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] fd_instr, fd_imm;
  logic [31:0] fd_pc;
  logic        fd_valid, booting;

  logic [15:0] mem [0:1023];
  assign imem_data = mem[imem_addr[9:0]];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fd_instr    (fd_instr),
    .fd_imm      (fd_imm),
    .fd_pc       (fd_pc),
    .fd_valid    (fd_valid),
    .booting     (booting)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc = '0;
  logic        redirect_live = 1'b0;
  logic [31:0] redirect_target = '0;
  int          checks = 0;
  int          errors = 0;
  int          n_valid = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Architectural view: an instruction at pc is one word, or two words when
  // its top three bits are 110; the next instruction follows it directly.
  function automatic void push_one();
    logic [15:0] w;
    logic [31:0] nxt;
    exp_t        e;
    w   = mem[model_pc[9:0]];
    nxt = model_pc + 32'd1;
    if (w[15:13] == 3'b110) begin
      e = '{instr: w, imm: mem[nxt[9:0]], pc: model_pc};
      model_pc = model_pc + 32'd2;
    end else begin
      e = '{instr: w, imm: 16'h0, pc: model_pc};
      model_pc = nxt;
    end
    exp_q.push_back(e);
  endfunction

  function automatic void refill();
    while (exp_q.size() < 16) push_one();
  endfunction

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st;
    if (rd && !booting) begin
      redirect        = 1'b1;
      redirect_pc     = rpc;
      redirect_live   = 1'b1;
      redirect_target = rpc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (redirect_live) begin
      exp_q.delete();
      model_pc      = redirect_target;
      redirect_live = 1'b0;
      redirect      = 1'b0;
    end
    refill();
  endtask

  task automatic random_phase(input int n);
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'h100;
        1:       rpc = {22'h0, 10'($urandom)};
        2:       rpc = 32'hFFFF_FFFE;
        default: rpc = $urandom;
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rpc);
      step();
    end
    drive(1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: an output is new only if the edge that produced it was not stalled.
  logic prev_stall = 1'b0;
  logic prev_redirect = 1'b0;
  logic held_valid = 1'b0;
  exp_t last_exp = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_stall    = 1'b0;
      prev_redirect = 1'b0;
      held_valid    = 1'b0;
    end else begin
      if (prev_redirect) begin
        check("redirect_bubble", {63'h0, fd_valid}, 64'h0);
        held_valid = 1'b0;
      end else if (prev_stall) begin
        check("stall_hold_valid", {63'h0, fd_valid}, {63'h0, held_valid});
        if (held_valid && fd_valid)
          check("stall_hold_out", {fd_instr, fd_imm, fd_pc}, last_exp);
      end else if (fd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {32'h0, fd_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_instr", {48'h0, fd_instr}, {48'h0, e.instr});
          check("out_imm", {48'h0, fd_imm}, {48'h0, e.imm});
          check("out_pc", {32'h0, fd_pc}, {32'h0, e.pc});
          last_exp = e;
        end
        held_valid = 1'b1;
        n_valid++;
      end else begin
        held_valid = 1'b0;
      end
      prev_stall    = stall;
      prev_redirect = redirect && !booting;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0]     = 16'h0000;
    mem[1]     = 16'h0020;
    mem[32'h20] = 16'h1000;
    mem[32'h21] = 16'h1080;
    mem[32'h22] = 16'h1100;
    mem[32'h23] = 16'hC000;
    mem[32'h24] = 16'hBEEF;
    mem[32'h25] = 16'hC123;
    mem[32'h26] = 16'h5555;
    mem[32'h100] = 16'h1ABC;
    mem[32'h3FF] = 16'h1234;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'h0, fd_valid}, 64'h0);
    check("rst_instr", {48'h0, fd_instr}, 64'h0);
    check("rst_imm", {48'h0, fd_imm}, 64'h0);
    check("rst_pc", {32'h0, fd_pc}, 64'h0);
    check("rst_booting", {63'h0, booting}, 64'h1);
    check("rst_addr", {43'h0, imem_addr}, 64'h0);

    reset = 1'b1;
    exp_q.delete();
    model_pc = {mem[0], mem[1]};
    refill();

    step();
    check("boot1_booting", {63'h0, booting}, 64'h1);
    check("boot1_addr", {43'h0, imem_addr}, 64'h1);
    step();
    check("boot2_booting", {63'h0, booting}, 64'h0);
    check("boot2_addr", {43'h0, imem_addr}, 64'h20);
    check("boot2_valid", {63'h0, fd_valid}, 64'h0);
    step();
    check("first_valid", {63'h0, fd_valid}, 64'h1);
    check("first_pc", {32'h0, fd_pc}, 64'h20);
    step();
    step();
    step();
    check("imm_bubble", {63'h0, fd_valid}, 64'h0);
    check("imm_addr", {43'h0, imem_addr}, 64'h24);
    drive(1'b1, 1'b0, 32'h0);
    repeat (3) begin
      step();
      check("imm_stall_addr", {43'h0, imem_addr}, 64'h24);
    end
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("two_word_imm", {48'h0, fd_imm}, 64'hBEEF);
    check("two_word_pc", {32'h0, fd_pc}, 64'h23);
    check("after_two_word_addr", {43'h0, imem_addr}, 64'h25);
    step();
    drive(1'b1, 1'b1, 32'h100);
    step();
    check("redir_valid", {63'h0, fd_valid}, 64'h0);
    check("redir_addr", {43'h0, imem_addr}, 64'h100);
    drive(1'b0, 1'b0, 32'h0);
    step();
    check("redir_target_pc", {32'h0, fd_pc}, 64'h100);
    check("redir_target_instr", {48'h0, fd_instr}, 64'h1ABC);

    random_phase(1500);

    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {63'h0, fd_valid}, 64'h0);
    check("async_rst_pc", {32'h0, fd_pc}, 64'h0);
    check("async_rst_instr", {48'h0, fd_instr}, 64'h0);
    check("async_rst_booting", {63'h0, booting}, 64'h1);
    check("async_rst_addr", {43'h0, imem_addr}, 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    mem[0] = 16'hFFFF;
    mem[1] = 16'hFFFF;
    reset = 1'b1;
    model_pc = 32'hFFFF_FFFF;
    refill();
    step();
    step();
    check("wrap_fetch_addr", {43'h0, imem_addr}, 64'h1F_FFFF);
    step();
    check("wrap_pc", {32'h0, fd_pc}, 64'hFFFF_FFFF);
    check("wrap_instr", {48'h0, fd_instr}, 64'h1234);
    check("wrap_next_addr", {43'h0, imem_addr}, 64'h0);

    random_phase(800);
    repeat (4) step();
    check("liveness_outputs", {63'h0, n_valid > 500}, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
